// File: rtl/sa_ctrl_sequencer_if.sv
// rtl/sa_ctrl_sequencer_if.sv - job command and SRAM window bus between a host and sa_ctrl_sequencer
interface sa_ctrl_sequencer_if #(
   parameter int AW = 5,
   parameter int CW = 4
);
   logic          i_start;
   logic          i_abort;
   logic [AW-1:0] i_top_start_addr;
   logic [AW-1:0] i_top_end_addr;
   logic [AW-1:0] i_left_start_addr;
   logic [AW-1:0] i_left_end_addr;
   logic [AW-1:0] i_down_base_addr;
   logic [CW-1:0] o_ctrl_state;
   logic [AW-1:0] o_top_sram_rd_start_addr;
   logic [AW-1:0] o_top_sram_rd_end_addr;
   logic [AW-1:0] o_left_sram_rd_start_addr;
   logic [AW-1:0] o_left_sram_rd_end_addr;
   logic [AW-1:0] o_down_sram_rd_start_addr;
   logic [AW-1:0] o_down_sram_rd_end_addr;
   logic          o_busy;
   logic          o_done;
   logic          o_err;

   modport master (
      output i_start, i_abort, i_top_start_addr, i_top_end_addr,
             i_left_start_addr, i_left_end_addr, i_down_base_addr,
      input  o_ctrl_state, o_top_sram_rd_start_addr, o_top_sram_rd_end_addr,
             o_left_sram_rd_start_addr, o_left_sram_rd_end_addr,
             o_down_sram_rd_start_addr, o_down_sram_rd_end_addr,
             o_busy, o_done, o_err
   );

   modport slave (
      input  i_start, i_abort, i_top_start_addr, i_top_end_addr,
             i_left_start_addr, i_left_end_addr, i_down_base_addr,
      output o_ctrl_state, o_top_sram_rd_start_addr, o_top_sram_rd_end_addr,
             o_left_sram_rd_start_addr, o_left_sram_rd_end_addr,
             o_down_sram_rd_start_addr, o_down_sram_rd_end_addr,
             o_busy, o_done, o_err
   );
endinterface

// File: rtl/sa_ctrl_sequencer.sv
// rtl/sa_ctrl_sequencer.sv - sequences systolic array ctrl state IDLE->WARMUP->STEADY->DRAIN with latched SRAM windows
module sa_ctrl_sequencer #(
   parameter int NUM_ROW              = 4,
   parameter int NUM_COL              = 4,
   parameter int LOG2_SRAM_BANK_DEPTH = 5,
   parameter int CTRL_WIDTH           = 4
) (
   input logic              clk,
   input logic              rst_n,
   sa_ctrl_sequencer_if.slave bus
);
   localparam int AW        = LOG2_SRAM_BANK_DEPTH;
   localparam int DRAIN_LEN = NUM_ROW + NUM_COL - 1;
   localparam int DLW       = $clog2(DRAIN_LEN + 1);
   // Counter holds "cycles left minus one": K-1 fits in AW bits
   localparam int CNTW      = (AW > DLW) ? AW : DLW;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_WARMUP = 2'd1;
   localparam logic [1:0] ST_STEADY = 2'd2;
   localparam logic [1:0] ST_DRAIN  = 2'd3;

   logic [1:0]      state_q, state_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic [AW-1:0]   top_s_q, top_s_d, top_e_q, top_e_d;
   logic [AW-1:0]   left_s_q, left_s_d, left_e_q, left_e_d;
   logic [AW-1:0]   down_s_q, down_s_d, down_e_q, down_e_d;
   logic            busy_q, busy_d, done_q, done_d, err_q, err_d;

   logic [AW-1:0]   top_span, left_span, k_m1;
   logic            start_ok;

   assign top_span  = bus.i_top_end_addr - bus.i_top_start_addr;
   assign left_span = bus.i_left_end_addr - bus.i_left_start_addr;
   assign start_ok  = (bus.i_top_end_addr >= bus.i_top_start_addr) &&
                      (bus.i_left_end_addr >= bus.i_left_start_addr) &&
                      (top_span == left_span);
   assign k_m1      = top_e_q - top_s_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      top_s_d  = top_s_q;
      top_e_d  = top_e_q;
      left_s_d = left_s_q;
      left_e_d = left_e_q;
      down_s_d = down_s_q;
      down_e_d = down_e_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.i_start && !bus.i_abort) begin
               if (start_ok) begin
                  top_s_d  = bus.i_top_start_addr;
                  top_e_d  = bus.i_top_end_addr;
                  left_s_d = bus.i_left_start_addr;
                  left_e_d = bus.i_left_end_addr;
                  down_s_d = bus.i_down_base_addr;
                  down_e_d = bus.i_down_base_addr + AW'(NUM_ROW - 1);
                  state_d  = ST_WARMUP;
                  cnt_d    = CNTW'(NUM_ROW - 1);
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_WARMUP: begin
            if (cnt_q == '0) begin
               state_d = ST_STEADY;
               cnt_d   = CNTW'(k_m1);
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_STEADY: begin
            if (cnt_q == '0) begin
               state_d = ST_DRAIN;
               cnt_d   = CNTW'(DRAIN_LEN - 1);
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_DRAIN: begin
            if (cnt_q == '0) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Abort drops the job without completion; latched windows stay visible
      if (state_q != ST_IDLE && bus.i_abort) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         done_d  = 1'b0;
      end
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         top_s_q  <= '0;
         top_e_q  <= '0;
         left_s_q <= '0;
         left_e_q <= '0;
         down_s_q <= '0;
         down_e_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         top_s_q  <= top_s_d;
         top_e_q  <= top_e_d;
         left_s_q <= left_s_d;
         left_e_q <= left_e_d;
         down_s_q <= down_s_d;
         down_e_q <= down_e_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign bus.o_ctrl_state              = CTRL_WIDTH'(state_q);
   assign bus.o_top_sram_rd_start_addr  = top_s_q;
   assign bus.o_top_sram_rd_end_addr    = top_e_q;
   assign bus.o_left_sram_rd_start_addr = left_s_q;
   assign bus.o_left_sram_rd_end_addr   = left_e_q;
   assign bus.o_down_sram_rd_start_addr = down_s_q;
   assign bus.o_down_sram_rd_end_addr   = down_e_q;
   assign bus.o_busy                    = busy_q;
   assign bus.o_done                    = done_q;
   assign bus.o_err                     = err_q;
endmodule

// File: tb/tb_sa_ctrl_sequencer.sv
// tb/tb_sa_ctrl_sequencer.sv - scoreboard bench for sa_ctrl_sequencer
module tb_sa_ctrl_sequencer;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   sa_ctrl_sequencer_if #(.AW(5), .CW(4)) bus ();

   sa_ctrl_sequencer #(
      .NUM_ROW(4), .NUM_COL(4), .LOG2_SRAM_BANK_DEPTH(5), .CTRL_WIDTH(4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] st;
      logic       busy, done, err;
      logic [4:0] ts, te, ls, le, ds, de;
   } exp_t;

   exp_t       q[$];
   logic [4:0] m_ts, m_te, m_ls, m_le, m_ds, m_de;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [1:0] st, input logic busy, input logic done, input logic err);
      exp_t e;
      e.st = st; e.busy = busy; e.done = done; e.err = err;
      e.ts = m_ts; e.te = m_te; e.ls = m_ls; e.le = m_le; e.ds = m_ds; e.de = m_de;
      q.push_back(e);
   endtask

   // Model of an accepted start: latch the currently driven window, then the full state trace
   task automatic push_job(input int k);
      m_ts = bus.i_top_start_addr;  m_te = bus.i_top_end_addr;
      m_ls = bus.i_left_start_addr; m_le = bus.i_left_end_addr;
      m_ds = bus.i_down_base_addr;  m_de = bus.i_down_base_addr + 5'd3;
      for (int i = 0; i < 4; i++) push(2'd1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < k; i++) push(2'd2, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) push(2'd3, 1'b1, 1'b0, 1'b0);
      push(2'd0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic step();
      exp_t e;
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         check("state", 32'(bus.o_ctrl_state), 32'(e.st));
         check("busy", 32'(bus.o_busy), 32'(e.busy));
         check("done", 32'(bus.o_done), 32'(e.done));
         check("err", 32'(bus.o_err), 32'(e.err));
         check("top_start", 32'(bus.o_top_sram_rd_start_addr), 32'(e.ts));
         check("top_end", 32'(bus.o_top_sram_rd_end_addr), 32'(e.te));
         check("left_start", 32'(bus.o_left_sram_rd_start_addr), 32'(e.ls));
         check("left_end", 32'(bus.o_left_sram_rd_end_addr), 32'(e.le));
         check("down_start", 32'(bus.o_down_sram_rd_start_addr), 32'(e.ds));
         check("down_end", 32'(bus.o_down_sram_rd_end_addr), 32'(e.de));
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && q.size() > 0; i++) step();
      check("queue_empty", 32'(q.size()), 32'd0);
   endtask

   task automatic set_win(input logic [4:0] ts, input logic [4:0] te, input logic [4:0] ls,
                          input logic [4:0] le, input logic [4:0] ds);
      bus.i_top_start_addr = ts;  bus.i_top_end_addr = te;
      bus.i_left_start_addr = ls; bus.i_left_end_addr = le;
      bus.i_down_base_addr = ds;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      m_ts = '0; m_te = '0; m_ls = '0; m_le = '0; m_ds = '0; m_de = '0;
      rst_n = 1'b0;
      bus.i_start = 1'b0;
      bus.i_abort = 1'b0;
      set_win(5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
      #22;
      check("rst_state", 32'(bus.o_ctrl_state), 32'd0);
      check("rst_busy", 32'(bus.o_busy), 32'd0);
      check("rst_done", 32'(bus.o_done), 32'd0);
      check("rst_err", 32'(bus.o_err), 32'd0);
      check("rst_down_end", 32'(bus.o_down_sram_rd_end_addr), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      push(2'd0, 1'b0, 1'b0, 1'b0);
      step();

      // 4x4, K=4, down base 30 wraps to down end 1; inputs scrambled while busy
      set_win(5'd0, 5'd3, 5'd0, 5'd3, 5'd30);
      bus.i_start = 1'b1;
      push_job(4);
      push(2'd0, 1'b0, 1'b0, 1'b0);
      step();
      bus.i_start = 1'b0;
      set_win(5'd7, 5'd9, 5'd1, 5'd2, 5'd11);
      step();
      bus.i_start = 1'b1;
      step();
      bus.i_start = 1'b0;
      drain();

      // left length mismatch
      set_win(5'd0, 5'd3, 5'd0, 5'd4, 5'd9);
      bus.i_start = 1'b1;
      push(2'd0, 1'b0, 1'b0, 1'b1);
      step();
      bus.i_start = 1'b0;
      push(2'd0, 1'b0, 1'b0, 1'b0);
      drain();

      // top end below start
      set_win(5'd5, 5'd4, 5'd5, 5'd4, 5'd9);
      bus.i_start = 1'b1;
      push(2'd0, 1'b0, 1'b0, 1'b1);
      step();
      bus.i_start = 1'b0;
      push(2'd0, 1'b0, 1'b0, 1'b0);
      drain();

      // K=32, full address space
      set_win(5'd0, 5'd31, 5'd0, 5'd31, 5'd2);
      bus.i_start = 1'b1;
      push_job(32);
      step();
      bus.i_start = 1'b0;
      drain();

      // abort in DRAIN cycle 3, then restart
      set_win(5'd2, 5'd5, 5'd10, 5'd13, 5'd4);
      bus.i_start = 1'b1;
      push_job(4);
      step();
      bus.i_start = 1'b0;
      for (int i = 0; i < 10; i++) step();
      bus.i_abort = 1'b1;
      q.delete();
      push(2'd0, 1'b0, 1'b0, 1'b0);
      push(2'd0, 1'b0, 1'b0, 1'b0);
      step();
      bus.i_abort = 1'b0;
      step();
      set_win(5'd1, 5'd2, 5'd3, 5'd4, 5'd31);
      bus.i_start = 1'b1;
      push_job(2);
      step();
      bus.i_start = 1'b0;
      drain();

      // abort and start together in IDLE: nothing happens
      set_win(5'd0, 5'd3, 5'd0, 5'd4, 5'd8);
      bus.i_start = 1'b1;
      bus.i_abort = 1'b1;
      push(2'd0, 1'b0, 1'b0, 1'b0);
      step();
      bus.i_start = 1'b0;
      bus.i_abort = 1'b0;
      drain();

      // start held across done: back-to-back jobs
      set_win(5'd0, 5'd3, 5'd4, 5'd7, 5'd0);
      bus.i_start = 1'b1;
      push_job(4);
      push_job(4);
      for (int i = 0; i < 17; i++) step();
      bus.i_start = 1'b0;
      drain();

      // async reset mid-STEADY
      set_win(5'd0, 5'd3, 5'd0, 5'd3, 5'd5);
      bus.i_start = 1'b1;
      push_job(4);
      step();
      bus.i_start = 1'b0;
      for (int i = 0; i < 5; i++) step();
      #2;
      rst_n = 1'b0;
      #1;
      q.delete();
      check("arst_state", 32'(bus.o_ctrl_state), 32'd0);
      check("arst_busy", 32'(bus.o_busy), 32'd0);
      check("arst_done", 32'(bus.o_done), 32'd0);
      check("arst_top_end", 32'(bus.o_top_sram_rd_end_addr), 32'd0);
      check("arst_down_start", 32'(bus.o_down_sram_rd_start_addr), 32'd0);
      m_ts = '0; m_te = '0; m_ls = '0; m_le = '0; m_ds = '0; m_de = '0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) push(2'd0, 1'b0, 1'b0, 1'b0);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
